// File: rtl/dec_digit_packer.sv
// Packs an MSD-first BCD digit stream into a W-bit binary value with an error flag.
// Latency: result valid the cycle after the last digit is accepted.
// Backpressure: digit_ready low while a result is held; the result is held until out_ready.
module dec_digit_packer #(
    parameter int W    = 8,
    parameter int MAXD = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         digit_valid,
    input  logic [3:0]   digit,
    input  logic         digit_last,
    output logic         digit_ready,
    output logic         out_valid,
    output logic [W-1:0] out_value,
    output logic         out_err,
    input  logic         out_ready
);

    // cnt must hold MAXD+1, where it saturates
    localparam int CW = $clog2(MAXD + 2);

    localparam logic [CW:0]  CNT_MAXD = (CW + 1)'(MAXD);
    localparam logic [CW:0]  CNT_SAT  = (CW + 1)'(MAXD + 1);
    localparam logic [W+3:0] MAX_VAL  = {4'b0000, {W{1'b1}}};
    localparam logic [W+3:0] TEN      = (W + 4)'(10);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          err;

    logic [W+3:0]  nxt;
    logic [CW:0]   cnt_inc;
    logic [CW-1:0] cnt_nxt;
    logic          err_digit;
    logic          err_final;
    logic          take;

    assign digit_ready = (state == ST_ACC);

    always_comb begin
        nxt       = ({4'b0000, acc} * TEN) + {{W{1'b0}}, digit};
        cnt_inc   = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
        cnt_nxt   = (cnt_inc > CNT_SAT) ? CNT_SAT[CW-1:0] : cnt_inc[CW-1:0];
        err_digit = (digit > 4'd9) || (nxt > MAX_VAL) || (cnt_inc > CNT_MAXD);
        err_final = err || err_digit;
        take      = digit_valid && digit_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (take) begin
                        cnt <= cnt_nxt;
                        // once in error the accumulator freezes; digits are still counted
                        if (err_final) begin
                            err <= 1'b1;
                        end else begin
                            acc <= nxt[W-1:0];
                        end
                        if (digit_last) begin
                            state     <= ST_OUT;
                            out_valid <= 1'b1;
                            out_value <= err_final ? '0 : nxt[W-1:0];
                            out_err   <= err_final;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state     <= ST_ACC;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        err       <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_digit_packer.sv
// Randomized bench for dec_digit_packer against an integer-arithmetic reference model.
module tb_dec_digit_packer;

    localparam int W    = 8;
    localparam int MAXD = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         digit_valid = 1'b0;
    logic [3:0]   digit = 4'd0;
    logic         digit_last = 1'b0;
    logic         digit_ready;
    logic         out_valid;
    logic [W-1:0] out_value;
    logic         out_err;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0] num_q[$];

    dec_digit_packer #(.W(W), .MAXD(MAXD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_last  (digit_last),
        .digit_ready (digit_ready),
        .out_valid   (out_valid),
        .out_value   (out_value),
        .out_err     (out_err),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Decimal value of the digit list, with the error rules applied as plain arithmetic.
    task automatic model(output int v, output bit e);
        int val;
        val = 0;
        e   = 1'b0;
        for (int i = 0; i < num_q.size(); i++) begin
            if (num_q[i] > 4'd9) begin
                e = 1'b1;
            end else if (!e) begin
                val = val * 10 + int'(num_q[i]);
                if (val > (1 << W) - 1) e = 1'b1;
            end
            if (i + 1 > MAXD) e = 1'b1;
        end
        v = e ? 0 : val;
    endtask

    // Entered and left on a falling edge with the DUT ready for digits.
    task automatic run_num(input int stall, input logic [3:0] junk, input bit junk_vld,
                           input bit gaps);
        int ev;
        bit ee;
        model(ev, ee);
        for (int i = 0; i < num_q.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                digit_valid = 1'b0;
                digit       = 4'($urandom);
                digit_last  = 1'($urandom);
                @(negedge clk);
            end
            check("acc_ready", 32'(digit_ready), 32'd1);
            check("acc_ovalid", 32'(out_valid), 32'd0);
            digit_valid = 1'b1;
            digit       = num_q[i];
            digit_last  = (i == num_q.size() - 1);
            @(negedge clk);
        end
        digit_valid = junk_vld;
        digit       = junk;
        digit_last  = 1'($urandom);
        check("lat_ovalid", 32'(out_valid), 32'd1);
        check("value", 32'(out_value), 32'(ev));
        check("err", 32'(out_err), 32'(ee));
        check("out_dready", 32'(digit_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_ovalid", 32'(out_valid), 32'd1);
            check("hold_value", 32'(out_value), 32'(ev));
            check("hold_err", 32'(out_err), 32'(ee));
            check("hold_dready", 32'(digit_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready   = 1'b0;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        check("turn_dready", 32'(digit_ready), 32'd1);
        check("turn_ovalid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        check({tag, "_value"}, 32'(out_value), 32'd0);
        check({tag, "_err"}, 32'(out_err), 32'd0);
        check({tag, "_dready"}, 32'(digit_ready), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        num_q = '{4'd2, 4'd5, 4'd5};        run_num(0, 4'd0, 1'b0, 1'b0);
        num_q = '{4'd2, 4'd5, 4'd6};        run_num(0, 4'd0, 1'b0, 1'b0);
        num_q = '{4'd1, 4'd2};              run_num(0, 4'd0, 1'b0, 1'b0);
        num_q = '{4'd4, 4'hA, 4'd3};        run_num(0, 4'd0, 1'b0, 1'b0);
        num_q = '{4'd0, 4'd0, 4'd1, 4'd2};  run_num(0, 4'd0, 1'b0, 1'b0);
        num_q = '{4'd0, 4'd0, 4'd7};        run_num(0, 4'd0, 1'b0, 1'b0);
        num_q = '{4'd9};                    run_num(5, 4'd3, 1'b1, 1'b0);
        num_q = '{4'd3};                    run_num(0, 4'd0, 1'b0, 1'b0);

        // reset in the middle of a number
        digit_valid = 1'b1; digit = 4'd1; digit_last = 1'b0;
        @(negedge clk);
        digit = 4'd2;
        @(negedge clk);
        digit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        num_q = '{4'd4};                    run_num(0, 4'd0, 1'b0, 1'b0);

        // reset while a result is pending
        digit_valid = 1'b1; digit = 4'd8; digit_last = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0; digit_last = 1'b0;
        check("pend_ovalid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("outrst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        num_q = '{4'd6, 4'd1};              run_num(0, 4'd0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            int len;
            len = $urandom_range(1, MAXD + 2);
            num_q.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) num_q.push_back(4'($urandom_range(10, 15)));
                else if ($urandom_range(0, 3) == 0) num_q.push_back(4'd0);
                else num_q.push_back(4'($urandom_range(0, 9)));
            end
            run_num($urandom_range(0, 3), 4'($urandom), 1'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
